// File: rtl/ln_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// ln_share_arbiter_if
// Bundles the requester, response and layer_norm engine signals of
// ln_share_arbiter.
//   slave  : arbiter view (drives req_ready, resp_*, busy, ln_start, ln_x/gamma/beta)
//   master : environment view (drives req_valid/x/gamma/beta, resp_ready,
//            ln_done, ln_x_out)
// Port summary (widths: TW = DATA_WIDTH*SEQ_LEN*EMB_DIM, PW = DATA_WIDTH*EMB_DIM,
// IW = $clog2(NUM_REQ)):
//   req_valid/req_ready  NUM_REQ      request handshake, req_ready one-hot
//   req_x                NUM_REQ*TW   requester k at [k*TW +: TW]
//   req_gamma/req_beta   NUM_REQ*PW   requester k at [k*PW +: PW]
//   resp_valid/ready     1            response handshake
//   resp_id/data/err     IW/TW/1      response payload
//   busy                 1            arbiter not idle
//   ln_start/ln_done     1            engine control
//   ln_x/ln_gamma/ln_beta TW/PW/PW    engine operands
//   ln_x_out             TW           engine result
// ----------------------------------------------------------------------------
interface ln_share_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8
);
    localparam int TW = DATA_WIDTH * SEQ_LEN * EMB_DIM;
    localparam int PW = DATA_WIDTH * EMB_DIM;
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*TW-1:0] req_x;
    logic [NUM_REQ*PW-1:0] req_gamma;
    logic [NUM_REQ*PW-1:0] req_beta;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IW-1:0]         resp_id;
    logic [TW-1:0]         resp_data;
    logic                  resp_err;
    logic                  busy;
    logic                  ln_start;
    logic [TW-1:0]         ln_x;
    logic [PW-1:0]         ln_gamma;
    logic [PW-1:0]         ln_beta;
    logic                  ln_done;
    logic [TW-1:0]         ln_x_out;

    modport slave (
        input  req_valid, req_x, req_gamma, req_beta, resp_ready, ln_done, ln_x_out,
        output req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               ln_start, ln_x, ln_gamma, ln_beta
    );

    modport master (
        output req_valid, req_x, req_gamma, req_beta, resp_ready, ln_done, ln_x_out,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               ln_start, ln_x, ln_gamma, ln_beta
    );
endinterface

// File: rtl/ln_share_arbiter.sv
// ----------------------------------------------------------------------------
// ln_share_arbiter
// Time-shares one layer_norm engine among NUM_REQ requesters. A round-robin
// pick in IDLE captures the winner's x/gamma/beta into operand registers that
// drive the engine, ln_start is pulsed once, and the engine result is held in
// a response buffer together with the requester id until the consumer takes it.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high (abandons any job in flight)
//   bus   ln_share_arbiter_if.slave: request, response and engine signals
// Optional build macro: LN_WATCHDOG_EN
//   Defined   : WAIT aborts after TIMEOUT_CYC cycles without ln_done, returning
//               resp_data=0 and resp_err=1 (ln_done wins on a tie).
//   Undefined : no watchdog counter, resp_err is constant 0.
// ----------------------------------------------------------------------------
module ln_share_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int SEQ_LEN     = 8,
    parameter int EMB_DIM     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ln_share_arbiter_if.slave bus
);
    localparam int          TW = DATA_WIDTH * SEQ_LEN * EMB_DIM;
    localparam int          PW = DATA_WIDTH * EMB_DIM;
    localparam int          IW = $clog2(NUM_REQ);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      cur_id;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      cand;
    logic               any_req;
    logic [NUM_REQ-1:0] ready_vec;
    logic [TW-1:0]      op_x;
    logic [PW-1:0]      op_gamma;
    logic [PW-1:0]      op_beta;
    logic [TW-1:0]      resp_data_q;
    logic [IW-1:0]      resp_id_q;
    logic               resp_valid_q;
    logic               ln_start_q;
    logic               busy_q;

`ifdef LN_WATCHDOG_EN
    localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] wd_cnt;
    logic          resp_err_q;
`else
    // TIMEOUT_CYC has no effect without the watchdog.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    // Round-robin search starting just after the previous winner.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = IW'((32'(last_grant) + i) % NR);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

    // Acceptance must be visible in the same cycle as the grant, so req_ready
    // is decoded rather than registered; it is masked during reset because
    // the operand capture is blocked then.
    always_comb begin
        ready_vec = '0;
        if (state == S_IDLE && any_req && !rst) begin
            ready_vec[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last_grant   <= IW'(NUM_REQ - 1);
            cur_id       <= '0;
            op_x         <= '0;
            op_gamma     <= '0;
            op_beta      <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            ln_start_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef LN_WATCHDOG_EN
            wd_cnt       <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            ln_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        cur_id     <= grant;
                        op_x       <= bus.req_x[grant * TW +: TW];
                        op_gamma   <= bus.req_gamma[grant * PW +: PW];
                        op_beta    <= bus.req_beta[grant * PW +: PW];
                        ln_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef LN_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.ln_done) begin
                        resp_data_q  <= bus.ln_x_out;
                        resp_id_q    <= cur_id;
                        resp_valid_q <= 1'b1;
`ifdef LN_WATCHDOG_EN
                        resp_err_q   <= 1'b0;
`endif
                        state        <= S_RESP;
                    end
`ifdef LN_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        resp_data_q  <= '0;
                        resp_id_q    <= cur_id;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    // Returning to IDLE without a grant leaves the engine one
                    // idle cycle between done and the next start.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        last_grant   <= cur_id;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_q;
    assign bus.ln_start   = ln_start_q;
    assign bus.ln_x       = op_x;
    assign bus.ln_gamma   = op_gamma;
    assign bus.ln_beta    = op_beta;
`ifdef LN_WATCHDOG_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ln_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ln_share_arbiter
// Directed bench for ln_share_arbiter. A behavioural engine stands in for
// layer_norm: ln_done pulses a fixed number of cycles after ln_start with
// x_out[e] = x[e]*gamma[e%EMB] + beta[e%EMB] (16-bit wrap), computed from the
// operands present at done time. Build with LN_WATCHDOG_EN to add the
// watchdog sequence (TIMEOUT_CYC = 16).
// ----------------------------------------------------------------------------
module tb_ln_share_arbiter;
    localparam int NUM_REQ = 2;
    localparam int DW      = 16;
    localparam int SEQ_LEN = 8;
    localparam int EMB_DIM = 8;
`ifdef LN_WATCHDOG_EN
    localparam int TIMEOUT_CYC = 16;
`else
    localparam int TIMEOUT_CYC = 1024;
`endif
    localparam int TW  = DW * SEQ_LEN * EMB_DIM;
    localparam int PW  = DW * EMB_DIM;
    localparam int NEL = SEQ_LEN * EMB_DIM;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ln_share_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .SEQ_LEN(SEQ_LEN), .EMB_DIM(EMB_DIM)
    ) bus ();

    ln_share_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .SEQ_LEN(SEQ_LEN), .EMB_DIM(EMB_DIM),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [TW-1:0] ln_model(input logic [TW-1:0] x,
                                               input logic [PW-1:0] g,
                                               input logic [PW-1:0] b);
        logic [TW-1:0] r;
        r = '0;
        for (int e = 0; e < NEL; e++) begin
            int c;
            c = e % EMB_DIM;
            r[e*DW +: DW] = x[e*DW +: DW] * g[c*DW +: DW] + b[c*DW +: DW];
        end
        return r;
    endfunction

    // Engine stand-in
    int eng_lat = 4;
    bit eng_en  = 1'b1;
    int eng_cnt = 0;
    int n_start = 0;

    always @(posedge clk) begin
        if (rst) begin
            bus.ln_done  <= 1'b0;
            bus.ln_x_out <= '0;
            eng_cnt      <= 0;
        end else begin
            bus.ln_done <= 1'b0;
            if (bus.ln_start) begin
                eng_cnt <= eng_lat;
                n_start <= n_start + 1;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1 && eng_en) begin
                    bus.ln_done  <= 1'b1;
                    bus.ln_x_out <= ln_model(bus.ln_x, bus.ln_gamma, bus.ln_beta);
                end
            end
        end
    end

    // Stimulus images per requester
    logic [TW-1:0] sx [NUM_REQ];
    logic [PW-1:0] sg [NUM_REQ];
    logic [PW-1:0] sb [NUM_REQ];

    task automatic set_req(input int k, input logic [15:0] xb, input logic [15:0] g,
                           input logic [15:0] b);
        for (int e = 0; e < NEL; e++)
            sx[k][e*DW +: DW] = xb + 16'(e) + 16'(k * 256);
        for (int c = 0; c < EMB_DIM; c++) begin
            sg[k][c*DW +: DW] = g + 16'(k);
            sb[k][c*DW +: DW] = b + 16'(k * 16);
        end
        bus.req_x[k*TW +: TW]     = sx[k];
        bus.req_gamma[k*PW +: PW] = sg[k];
        bus.req_beta[k*PW +: PW]  = sb[k];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int e = 0; e < NEL; e++) begin
                if (act[e*DW +: DW] !== exp[e*DW +: DW]) begin
                    $display("FAIL %s: element %0d got 0x%0h expected 0x%0h",
                             nm, e, act[e*DW +: DW], exp[e*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    // Call right after a negedge with req_valid already driven.
    task automatic wait_grant(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.req_ready !== '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " grant seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_resp(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " resp seen"}, 64'(ok), 64'd1);
    endtask

    task automatic run_job(input logic [1:0] valid, input int exp_id,
                           input logic [15:0] exp_e0, input string tag);
        int s0;
        @(negedge clk);
        bus.req_valid = valid;
        s0 = n_start;
        wait_grant(tag);
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd1 << exp_id);
        @(negedge clk);
        bus.req_valid = '0;
        chk({tag, " ln_start"}, 64'(bus.ln_start), 64'd1);
        chk({tag, " busy"}, 64'(bus.busy), 64'd1);
        chk_data({tag, " ln_x"}, bus.ln_x, sx[exp_id]);
        chk_data({tag, " ln_gamma"}, TW'(bus.ln_gamma), TW'(sg[exp_id]));
        chk_data({tag, " ln_beta"}, TW'(bus.ln_beta), TW'(sb[exp_id]));
        @(negedge clk);
        chk({tag, " ln_start low"}, 64'(bus.ln_start), 64'd0);
        wait_resp(tag);
        chk({tag, " resp_id"}, 64'(bus.resp_id), 64'(exp_id));
        chk({tag, " resp_err"}, 64'(bus.resp_err), 64'd0);
        chk({tag, " elem0"}, 64'(bus.resp_data[15:0]), 64'(exp_e0));
        chk_data({tag, " resp_data"}, bus.resp_data, ln_model(sx[exp_id], sg[exp_id], sb[exp_id]));
        chk({tag, " starts"}, 64'(n_start - s0), 64'd1);
        @(negedge clk);
        chk({tag, " resp_valid drop"}, 64'(bus.resp_valid), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] xb;
        logic [15:0] g;
        logic [15:0] b;
        int          exp_id;
        logic [15:0] exp_e0;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int            ids [4];
        int            cnt;
        int            s0;
        int            k;
        logic [TW-1:0] d0;
        logic [TW-1:0] orig;
        logic [0:0]    i0;
        bit            stable;
        bit            nogrant;
        bit            hold_ok;
        bit            found;

        // Round-robin pointer enters the table at last_grant = 1.
        vecs[0] = '{2'b11, 16'd2,  16'd3, 16'd1, 0, 16'h0007};
        vecs[1] = '{2'b11, 16'd1,  16'd2, 16'd4, 1, 16'h0317};
        vecs[2] = '{2'b01, 16'd0,  16'd0, 16'd5, 0, 16'h0005};
        vecs[3] = '{2'b01, 16'd10, 16'd1, 16'd0, 0, 16'h000A};
        vecs[4] = '{2'b10, 16'd0,  16'd1, 16'd0, 1, 16'h0210};
        vecs[5] = '{2'b10, 16'd4,  16'd0, 16'd2, 1, 16'h0116};
        vecs[6] = '{2'b11, 16'd1,  16'd1, 16'd1, 0, 16'h0002};
        vecs[7] = '{2'b11, 16'd0,  16'd0, 16'd0, 1, 16'h0110};

        rst            = 1'b1;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 1'b1;
        bus.req_x      = '0;
        bus.req_gamma  = '0;
        bus.req_beta   = '0;
        set_req(0, 16'd1, 16'd1, 16'd0);
        set_req(1, 16'd2, 16'd1, 16'd0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst ln_start", 64'(bus.ln_start), 64'd0);
        chk("rst resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst resp_id", 64'(bus.resp_id), 64'd0);
        chk_data("rst resp_data", bus.resp_data, '0);
        chk_data("rst ln_x", bus.ln_x, '0);
        rst = 1'b0;

        // Fairness with both requesters held valid
        s0  = n_start;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                ids[cnt] = int'(bus.resp_id);
                cnt++;
                if (cnt == 4) begin
                    bus.req_valid = '0;
                    chk("rr starts", 64'(n_start - s0), 64'd4);
                end
            end
        end
        chk("rr count", 64'(cnt), 64'd4);
        chk("rr id0", 64'(ids[0]), 64'd0);
        chk("rr id1", 64'(ids[1]), 64'd1);
        chk("rr id2", 64'(ids[2]), 64'd0);
        chk("rr id3", 64'(ids[3]), 64'd1);
        @(negedge clk);

        // Table-driven jobs
        for (int i = 0; i < 8; i++) begin
            set_req(0, vecs[i].xb, vecs[i].g, vecs[i].b);
            set_req(1, vecs[i].xb, vecs[i].g, vecs[i].b);
            run_job(vecs[i].valid, vecs[i].exp_id, vecs[i].exp_e0, $sformatf("vec%0d", i));
        end

        // Response back-pressure: 20 stalled cycles
        set_req(0, 16'd3, 16'd2, 16'd1);
        set_req(1, 16'd9, 16'd9, 16'd9);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 2'b01;
        wait_grant("stall");
        chk("stall req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 2'b11;
        wait_resp("stall");
        s0      = n_start;
        d0      = bus.resp_data;
        i0      = bus.resp_id;
        stable  = 1'b1;
        nogrant = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== d0 || bus.resp_id !== i0)
                stable = 1'b0;
            if (bus.req_ready !== '0)
                nogrant = 1'b0;
        end
        chk("stall stable", 64'(stable), 64'd1);
        chk("stall no grant", 64'(nogrant), 64'd1);
        chk("stall no start", 64'(n_start - s0), 64'd0);
        chk("stall resp_id", 64'(bus.resp_id), 64'd0);
        chk("stall elem0", 64'(bus.resp_data[15:0]), 64'h7);
        chk_data("stall resp_data", bus.resp_data, ln_model(sx[0], sg[0], sb[0]));
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        @(negedge clk);
        chk("stall resp_valid drop", 64'(bus.resp_valid), 64'd0);

        // Operand capture: requester 1 changes its inputs right after grant
        eng_lat = 8;
        set_req(1, 16'd5, 16'd3, 16'd2);
        orig = sx[1];
        @(negedge clk);
        bus.req_valid = 2'b10;
        wait_grant("hold");
        chk("hold req_ready", 64'(bus.req_ready), 64'd2);
        @(negedge clk);
        bus.req_valid          = '0;
        bus.req_x[TW +: TW]    = ~orig;
        bus.req_gamma[PW +: PW] = ~sg[1];
        hold_ok = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ln_x !== orig) hold_ok = 1'b0;
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("hold ln_x stable", 64'(hold_ok), 64'd1);
        chk("hold resp seen", 64'(found), 64'd1);
        chk("hold resp_id", 64'(bus.resp_id), 64'd1);
        chk_data("hold resp_data", bus.resp_data, ln_model(orig, sg[1], sb[1]));
        @(negedge clk);
        eng_lat = 4;
        bus.req_x[TW +: TW]     = sx[1];
        bus.req_gamma[PW +: PW] = sg[1];

        // Reset in the middle of WAIT; pointer would otherwise favour req 1
        set_req(0, 16'd7, 16'd2, 16'd3);
        @(negedge clk);
        bus.req_valid = 2'b01;
        wait_grant("mid-rst");
        chk("mid-rst req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        chk("mid-rst busy", 64'(bus.busy), 64'd0);
        chk("mid-rst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("mid-rst req_ready", 64'(bus.req_ready), 64'd0);
        chk_data("mid-rst resp_data", bus.resp_data, '0);
        chk_data("mid-rst ln_x", bus.ln_x, '0);
        rst = 1'b0;
        #1;
        chk("post-rst grant", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp("post-rst");
        chk("post-rst resp_id", 64'(bus.resp_id), 64'd0);
        chk("post-rst elem0", 64'(bus.resp_data[15:0]), 64'd17);
        @(negedge clk);

`ifdef LN_WATCHDOG_EN
        // Engine never answers: watchdog abort
        eng_en = 1'b0;
        set_req(1, 16'd1, 16'd1, 16'd1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        wait_grant("wd");
        @(negedge clk);
        bus.req_valid = '0;
        chk("wd ln_start", 64'(bus.ln_start), 64'd1);
        k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid === 1'b1) break;
        end
        chk("wd latency", 64'(k), 64'd17);
        chk("wd resp_err", 64'(bus.resp_err), 64'd1);
        chk("wd resp_id", 64'(bus.resp_id), 64'd1);
        chk_data("wd resp_data", bus.resp_data, '0);
        @(negedge clk);
        eng_en = 1'b1;
`else
        k = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
